// File: rtl/mpc_pkg.sv
// Shared types and constants for the ingress FIFO drain logic.
package mpc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } rd_state_t;

    localparam int unsigned HDR_LEN_LSB     = 0;
    localparam int unsigned DEFAULT_MAX_LEN = 64;

endpackage

// File: rtl/input_fifo_reader.sv
// Drains one FWFT ingress FIFO: parses a length header, forwards that many payload words
// as a framed valid/ready stream and discards packets whose length is illegal.
module input_fifo_reader
    import mpc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned MAX_LEN    = DEFAULT_MAX_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    input  logic                  out_ready,
    output logic                  hdr_valid,
    output logic [LEN_WIDTH-1:0]  hdr_len,
    output logic                  err_len,
    output logic                  busy
);

    rd_state_t             state_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [LEN_WIDTH-1:0]  hdr_len_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_sop_q;
    logic                  out_eop_q;
    logic                  hdr_valid_q;
    logic                  err_len_q;

    logic [LEN_WIDTH-1:0]  head_len;
    logic                  len_zero;
    logic                  len_over;
    logic                  out_free;
    logic                  rem_last;

    assign head_len = fifo_dout[HDR_LEN_LSB +: LEN_WIDTH];
    assign len_zero = (head_len == '0);
    assign len_over = (32'(head_len) > MAX_LEN);
    assign out_free = !out_valid_q || out_ready;
    assign rem_last = (rem_q == LEN_WIDTH'(1));

    always_comb begin
        fifo_rd_en = 1'b0;
        if (!rst && !fifo_empty) begin
            unique case (state_q)
                IDLE, DROP: fifo_rd_en = 1'b1;
                BODY:       fifo_rd_en = out_free;
                default:    fifo_rd_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            hdr_len_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            hdr_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            hdr_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (fifo_rd_en) begin
                        if (len_zero) begin
                            err_len_q <= 1'b1;
                        end else if (len_over) begin
                            err_len_q <= 1'b1;
                            rem_q     <= head_len;
                            state_q   <= DROP;
                        end else begin
                            hdr_valid_q <= 1'b1;
                            hdr_len_q   <= head_len;
                            rem_q       <= head_len;
                            state_q     <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (fifo_rd_en) begin
                        // rem still equals the header length only on the first payload pop
                        out_valid_q <= 1'b1;
                        out_data_q  <= fifo_dout;
                        out_sop_q   <= (rem_q == hdr_len_q);
                        out_eop_q   <= rem_last;
                        rem_q       <= rem_q - LEN_WIDTH'(1);
                        if (rem_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (fifo_rd_en) begin
                        rem_q <= rem_q - LEN_WIDTH'(1);
                        if (rem_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign hdr_valid = hdr_valid_q;
    assign hdr_len   = hdr_len_q;
    assign err_len   = err_len_q;
    assign busy      = (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_input_fifo_reader.sv
// Bench for input_fifo_reader: a FIFO model feeds directed packets; expected words and
// header events are derived from the packet list, plus literal cycle-level expectations.
module tb_input_fifo_reader;

    localparam int DW = 16;
    localparam int LW = 8;
    localparam int ML = 64;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic          out_ready = 1'b1;
    logic          hdr_valid;
    logic [LW-1:0] hdr_len;
    logic          err_len;
    logic          busy;

    logic [DW-1:0] mem [0:4095];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          starve = 1'b1;
    logic          flush  = 1'b0;

    word_t exp_q[$];
    int    ev_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    assign fifo_dout  = mem[rd_ptr];
    assign fifo_empty = starve || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    input_fifo_reader #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .MAX_LEN   (ML)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_ready (out_ready),
        .hdr_valid (hdr_valid),
        .hdr_len   (hdr_len),
        .err_len   (err_len),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got unexpected event, expected none at %0t", name, $time);
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    // Model: a packet is legal iff 1 <= len <= ML; only legal payloads reach the stream.
    task automatic push_pkt(input int len, input logic [DW-1:0] base, input logic [7:0] hi);
        word_t w;
        logic  legal;
        legal = (len >= 1) && (len <= ML);
        push_word({hi, 8'(len)});
        ev_q.push_back(legal ? len : -1);
        for (int i = 0; i < len; i++) begin
            push_word(DW'(base + DW'(i)));
            if (legal) begin
                w.d   = DW'(base + DW'(i));
                w.sop = (i == 0);
                w.eop = (i == len - 1);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((rd_ptr != wr_ptr || busy || exp_q.size() != 0 || ev_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 1000), 32'd1);
    endtask

    // Compare process: every handshake, hold and header/error pulse against the model.
    logic  hold_pend = 1'b0;
    word_t held;
    always @(negedge clk) begin
        word_t e;
        int    ev;
        check("rd_en_guard", 32'(fifo_rd_en && (fifo_empty || rst)), 32'd0);
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_word", 32'({out_data, out_sop, out_eop}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("extra_word");
                else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_sop", 32'(out_sop), 32'(e.sop));
                    check("out_eop", 32'(out_eop), 32'(e.eop));
                end
            end
            hold_pend = out_valid && !out_ready;
            held      = '{d: out_data, sop: out_sop, eop: out_eop};
            check("hdr_err_exclusive", 32'(hdr_valid && err_len), 32'd0);
            if (hdr_valid) begin
                if (ev_q.size() == 0) fail_now("extra_hdr_valid");
                else begin
                    ev = ev_q.pop_front();
                    check("hdr_len", 32'(hdr_len), 32'(ev));
                end
            end
            if (err_len) begin
                if (ev_q.size() == 0) fail_now("extra_err_len");
                else begin
                    ev = ev_q.pop_front();
                    check("err_len_kind", 32'(ev), 32'hFFFF_FFFF);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset values
        repeat (3) step();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({out_sop, out_eop, hdr_valid, err_len}), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_hdr_len", 32'(hdr_len), 32'd0);
        check("rst_busy_rd", 32'({busy, fifo_rd_en}), 32'd0);
        step();
        rst = 1'b0;

        // Basic L=3 packet, exact timing
        push_pkt(3, 16'hA1, 8'h00);
        step();
        starve = 1'b0;
        @(negedge clk);
        check("t1_rd_en_hdr", 32'(fifo_rd_en), 32'd1);
        check("t1_idle_busy", 32'({busy, hdr_valid}), 32'd0);
        @(negedge clk);
        check("t1_hdr_valid", 32'(hdr_valid), 32'd1);
        check("t1_hdr_len", 32'(hdr_len), 32'd3);
        check("t1_no_out_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1_w1", 32'({out_valid, out_data, out_sop, out_eop}), {13'd0, 1'b1, 16'hA1, 2'b10});
        @(negedge clk);
        check("t1_w2", 32'({out_valid, out_data, out_sop, out_eop}), {13'd0, 1'b1, 16'hA2, 2'b00});
        @(negedge clk);
        check("t1_w3", 32'({out_valid, out_data, out_sop, out_eop}), {13'd0, 1'b1, 16'hA3, 2'b01});
        @(negedge clk);
        check("t1_done", 32'({out_valid, busy}), 32'd0);
        drain();

        // Backpressure on the second word; upper header bits must be ignored
        starve = 1'b1;
        push_pkt(3, 16'hB1, 8'hA5);
        step();
        starve = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("t2_held_a2", 32'(out_data), 32'hB2);
        check("t2_no_pop_hold", 32'(fifo_rd_en), 32'd0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_still_a2", 32'({out_valid, out_data}), {15'd0, 1'b1, 16'hB2});
        check("t2_pop_resume", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        check("t2_a3_eop", 32'({out_data, out_eop}), {15'd0, 16'hB3, 1'b1});
        drain();

        // Zero length, legal boundaries, oversize drops
        push_pkt(0, 16'h0, 8'h00);
        push_pkt(1, 16'hC1, 8'h00);
        push_pkt(70, 16'h7000, 8'h00);
        push_pkt(2, 16'hD1, 8'h00);
        push_pkt(65, 16'h6500, 8'h3C);
        push_pkt(64, 16'h4000, 8'h00);
        push_pkt(255, 16'h9000, 8'h00);
        push_pkt(1, 16'hE1, 8'hFF);
        drain();

        // DROP ignores backpressure
        out_ready = 1'b0;
        push_pkt(70, 16'h8000, 8'h00);
        n = 0;
        while (rd_ptr != wr_ptr && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_drop_ignores_ready", 32'(rd_ptr == wr_ptr), 32'd1);
        check("t4_drop_no_out", 32'(out_valid), 32'd0);
        step();
        out_ready = 1'b1;
        drain();

        // FIFO runs dry mid-packet
        push_word(16'h0004);
        ev_q.push_back(4);
        for (int i = 0; i < 4; i++) exp_q.push_back('{d: 16'hF0 + 16'(i), sop: (i == 0), eop: (i == 3)});
        push_word(16'hF0);
        push_word(16'hF1);
        repeat (6) step();
        check("t5_stall_busy", 32'(busy), 32'd1);
        push_word(16'hF2);
        push_word(16'hF3);
        drain();

        // Back-to-back packets: one bubble between eop and next sop
        starve = 1'b1;
        push_pkt(2, 16'h5100, 8'h00);
        push_pkt(2, 16'h5200, 8'h00);
        step();
        starve = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_hdr1", 32'(hdr_valid), 32'd1);
        @(negedge clk);
        check("t6_p1_sop", 32'({out_valid, out_sop, out_data}), {15'd0, 2'b11, 16'h5100});
        @(negedge clk);
        check("t6_p1_eop", 32'({out_valid, out_eop, out_data}), {15'd0, 2'b11, 16'h5101});
        @(negedge clk);
        check("t6_bubble", 32'(out_valid), 32'd0);
        check("t6_hdr2", 32'(hdr_valid), 32'd1);
        @(negedge clk);
        check("t6_p2_sop", 32'({out_valid, out_sop, out_data}), {15'd0, 2'b11, 16'h5200});
        drain();

        // Reset after the second of four payload words
        starve = 1'b1;
        push_pkt(4, 16'h6100, 8'h00);
        step();
        starve = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("t7_rd_en_in_rst", 32'(fifo_rd_en), 32'd0);
        step();
        rst   = 1'b0;
        flush = 1'b0;
        exp_q.delete();
        ev_q.delete();
        @(negedge clk);
        check("t7_after_rst", 32'({out_valid, busy, out_sop}), 32'd0);
        push_pkt(1, 16'h6F00, 8'h00);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_fifo_reader.md
# input_fifo_reader

Drain side of the per-port `input_fifo`, which runs in first-word-fall-through mode. The block pops a header word, extracts the payload length and forwards exactly that many payload words downstream on a valid/ready stream with `sop`/`eop` framing. Packets with illegal lengths are discarded with an error pulse. It sits between each ingress FIFO and the cache write arbiter, one instance per port.

## Interface
Parameters:
- `DATA_WIDTH`, 16: FIFO/stream word width.
- `LEN_WIDTH`, 8: header length field width, carried in header bits `[LEN_WIDTH-1:0]`. Must be ≤ `DATA_WIDTH`.
- `MAX_LEN`, 64: largest legal payload length in words.

Ports:
- `clk`  in  1: clock, all logic on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `fifo_dout`  in  DATA_WIDTH: FIFO head word, valid whenever `fifo_empty` = 0.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_en`  out  1: pop request; combinational; never high while `fifo_empty` = 1 or `rst` = 1.
- `out_data`  out  DATA_WIDTH: payload word.
- `out_valid`  out  1: `out_data` is valid.
- `out_sop`  out  1: first payload word of a packet, qualified by `out_valid`.
- `out_eop`  out  1: last payload word of a packet, qualified by `out_valid`.
- `out_ready`  in  1: downstream accepts the word when `out_valid` and `out_ready` are both high.
- `hdr_valid`  out  1: one-cycle pulse when a legal header has been accepted.
- `hdr_len`  out  LEN_WIDTH: length of the last accepted header, held until the next header.
- `err_len`  out  1: one-cycle pulse when a header with length 0 or length > `MAX_LEN` is popped.
- `busy`  out  1: state ≠ IDLE, or `out_valid` = 1.

## Operation
- FSM states:
  - IDLE. Pops the head word as a header whenever `!fifo_empty`. With `L` = header `[LEN_WIDTH-1:0]`:
    - `1 ≤ L ≤ MAX_LEN`: go to BODY, `rem` ← `L`, pulse `hdr_valid`, latch `hdr_len`.
    - `L` = 0: stay in IDLE, pulse `err_len`.
    - `L > MAX_LEN`: go to DROP, `rem` ← `L`, pulse `err_len`.
  - BODY. Pops a word when `!fifo_empty` and the output register is free (`!out_valid` or `out_ready`). Each pop loads the output register and decrements `rem`. `out_sop` = 1 on the first payload word. `out_eop` = 1 when `rem` = 1 at the pop, and the next state is IDLE.
  - DROP. Pops whenever `!fifo_empty` and ignores `out_ready`. Decrements `rem`, emits nothing, and returns to IDLE after the pop made at `rem` = 1.
- Output stage: a single register. It holds `out_data`, `out_sop` and `out_eop` stable while `out_valid && !out_ready`.
- `rem` width: `LEN_WIDTH` bits. Full `L` range, including 2^LEN_WIDTH−1, is valid in DROP; there is no wrap.
- Header bits above `LEN_WIDTH` are ignored.
- `fifo_empty` mid-packet: stall in place. No timeout, no state change.
- Reset mid-packet: the FSM returns to IDLE and the output register clears. The next FIFO word is treated as a header; upstream resets the FIFO in the same cycle.

## Timing
- Reset values: state IDLE, `rem` 0, `out_valid`/`out_sop`/`out_eop`/`hdr_valid`/`err_len` 0, `out_data` 0, `hdr_len` 0. Combinationally, `fifo_rd_en` = 0 and `busy` = 0.
- Header popped in cycle N:
  - `hdr_valid`/`err_len` are high in cycle N+1, and `hdr_len` is updated in N+1.
  - The first payload pop is at N+1 at the earliest, so the first `out_valid` is at N+2.
- Pop-to-`out_valid` latency is 1 cycle. With `out_ready` held high and the FIFO non-empty, throughput is one word per cycle.
- Per-packet overhead is exactly one bubble cycle, for the header. A new header pops in the cycle after the `eop` pop.
- In the same cycle, `out_ready` = 1 with `out_valid` = 1 allows a new pop, so there is no bubble in BODY.
- DROP consumes one word per cycle while the FIFO is non-empty.

## Structure
- Shared package `mpc_pkg`:
  - `rd_state_t` enum: IDLE, BODY, DROP.
  - Header field localparams: `HDR_LEN_LSB` = 0.
  - Default `MAX_LEN`.
- Single module; no sub-module. The counter, FSM and output register are inline.

## Test plan
- Header `L`=3 followed by `A1`,`A2`,`A3`, `out_ready` = 1 → `hdr_valid` at N+1 with `hdr_len` = 3. `out_valid` in N+2..N+4 carries `A1`(sop), `A2`, `A3`(eop).
- Same packet with `out_ready` low on the `A2` cycle → `A2` is held stable for 2 cycles. There is no pop during the hold, and no word is lost or duplicated.
- Header `L`=0, then header `L`=1 with `B1` → `err_len` pulse on the first header. `B1` is then output with `sop` = `eop` = 1.
- Header `L`=70 (> 64) with 70 filler words, then header `L`=2 with `C1`,`C2` → one `err_len` pulse, no `out_valid` for the fillers, then `C1`/`C2` are framed correctly.
- Two back-to-back `L`=2 packets, FIFO pre-filled → exactly one idle output cycle between the `eop` of packet 1 and the `sop` of packet 2.
- `rst` asserted after the 2nd of 4 payload words → next cycle `out_valid` = 0 and state IDLE. `fifo_rd_en` = 0 during reset, and the next FIFO word is parsed as a header.
